// File: rtl/z80mini_intctl_pkg.sv
// -----------------------------------------------------------------------------
// z80mini_pkg
// Shared definitions for the z80mini IM2 interrupt controller: register
// offsets within the four-port I/O window, the acknowledge FSM state type, the
// vector index used for spurious acknowledges, the maximum source count and a
// helper that builds the mask of implemented source bits.
// -----------------------------------------------------------------------------
package z80mini_pkg;

  localparam int NSRC_MAX = 8;

  // Register offsets selected by A[1:0]
  localparam logic [1:0] REG_MASK  = 2'd0;
  localparam logic [1:0] REG_VBASE = 2'd1;
  localparam logic [1:0] REG_PEND  = 2'd2;
  localparam logic [1:0] REG_INSRV = 2'd3;

  // Index placed in the vector when nothing was eligible at acknowledge time
  localparam logic [2:0] SPURIOUS_IDX = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } state_t;

  // Bits [nsrc-1:0] set; bits for unimplemented sources stay 0.
  function automatic logic [NSRC_MAX-1:0] src_mask(input int nsrc);
    logic [NSRC_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < NSRC_MAX; i++) begin
      if (i < nsrc) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/z80mini_intctl_if.sv
// -----------------------------------------------------------------------------
// z80mini_intctl_if
// Z80 bus slice seen by the interrupt controller.
//   clk0            one-clk strobe marking the CPU clock edge
//   a, d_in         CPU address A[7:0] and data bus input
//   n_iorq, n_m1,
//   n_rd, n_wr      Z80 bus controls, active-low
//   d_out, d_oe     read data / IM2 vector and its drive enable
//   int_n           0 = pull nINT low, 1 = release
// master: CPU/glue side driving the bus; slave: the controller.
// -----------------------------------------------------------------------------
interface z80mini_intctl_if;

  logic       clk0;
  logic [7:0] a;
  logic [7:0] d_in;
  logic       n_iorq;
  logic       n_m1;
  logic       n_rd;
  logic       n_wr;
  logic [7:0] d_out;
  logic       d_oe;
  logic       int_n;

  modport master (
    output clk0, a, d_in, n_iorq, n_m1, n_rd, n_wr,
    input  d_out, d_oe, int_n
  );

  modport slave (
    input  clk0, a, d_in, n_iorq, n_m1, n_rd, n_wr,
    output d_out, d_oe, int_n
  );

endinterface

// File: rtl/z80mini_intctl_irq_sync.sv
// -----------------------------------------------------------------------------
// z80mini_irq_sync
// Two-flop synchronizer for one asynchronous request line plus a rising-edge
// detector. rise is a one-clk pulse, high in the clk after the second
// synchronizer stage first sees the request high.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   irq    asynchronous request input
//   rise   one-clk pulse on a synchronized rising edge
// -----------------------------------------------------------------------------
module z80mini_irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

  // [0],[1] are the synchronizer; [2] holds the previous synchronized level.
  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= {sr[1:0], irq};
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/z80mini_intctl.sv
// -----------------------------------------------------------------------------
// z80mini_intctl
// Z80 mode-2 interrupt controller. Up to eight rising-edge requests are
// synchronized into a PEND register, masked, prioritised (source 0 highest)
// and signalled on nINT. During the interrupt-acknowledge cycle the IM2
// vector {VBASE[7:4], idx[2:0], 0} is driven onto the data bus.
//
// I/O window BASE_PORT..BASE_PORT+3:
//   +0 MASK  RW   +1 VBASE RW ([3:0] read 0)
//   +2 PEND  R, write 1s to clear
//   +3 INSRV R, any write is an EOI
//
// Build option: define Z80MINI_INTCTL_NESTING_EN to track in-service sources.
// An in-service source blocks itself and every lower priority until EOI.
// Without it INSRV reads 0 and EOI writes are ignored.
//
// Ports:
//   clk    system clock (50 MHz)
//   reset  synchronous, active-high
//   irq    NSRC asynchronous rising-edge requests
//   bus    z80mini_intctl_if.slave (CPU bus, data out/enable, int_n)
// -----------------------------------------------------------------------------
module z80mini_intctl
  import z80mini_pkg::*;
#(
  parameter int         NSRC      = 8,
  parameter logic [7:0] BASE_PORT = 8'hC0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   irq,
  z80mini_intctl_if.slave   bus
);

  localparam logic [NSRC_MAX-1:0] SRC_MASK = src_mask(NSRC);

  // ---------------------------------------------------------------------------
  // Request synchronizers
  // ---------------------------------------------------------------------------
  logic [NSRC_MAX-1:0] rise_v;

  for (genvar g = 0; g < NSRC_MAX; g++) begin : g_src
    if (g < NSRC) begin : g_used
      z80mini_irq_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .irq   (irq[g]),
        .rise  (rise_v[g])
      );
    end else begin : g_unused
      assign rise_v[g] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic port_hit, io_cyc, wr_stb, rd_stb, rd_hold;
  logic ack_stb, ack_exit, ack_entry;
  logic wr_mask, wr_vbase, wr_pend;

  state_t state_q, state_d;

  assign port_hit  = (bus.a[7:2] == BASE_PORT[7:2]);
  assign io_cyc    = bus.clk0 & ~bus.n_iorq & bus.n_m1 & port_hit;
  assign wr_stb    = io_cyc & ~bus.n_wr;
  assign rd_stb    = io_cyc & ~bus.n_rd;
  // Read stays active for as long as the CPU holds the I/O read on our window.
  assign rd_hold   = ~bus.n_iorq & ~bus.n_rd & bus.n_m1 & port_hit;

  assign ack_stb   = bus.clk0 & ~bus.n_m1 & ~bus.n_iorq;
  assign ack_exit  = bus.clk0 & (bus.n_m1 | bus.n_iorq);
  assign ack_entry = ack_stb & (state_q != ACK);

  assign wr_mask   = wr_stb & (bus.a[1:0] == REG_MASK);
  assign wr_vbase  = wr_stb & (bus.a[1:0] == REG_VBASE);
  assign wr_pend   = wr_stb & (bus.a[1:0] == REG_PEND);

  // ---------------------------------------------------------------------------
  // Registers and priority
  // ---------------------------------------------------------------------------
  logic [NSRC_MAX-1:0] mask, pending, insrv, blocked, eligible;
  logic [NSRC_MAX-1:0] win_hot, ack_clr, pend_clr;
  logic [3:0]          vbase_hi;
  logic [2:0]          win_idx, ack_idx;
  logic                any_elig, int_n_q, rd_active;

  assign eligible = pending & mask & ~blocked;
  assign any_elig = |eligible;

  // Lowest set index wins; SPURIOUS_IDX when nothing is eligible.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    win_idx = SPURIOUS_IDX;
    win_hot = '0;
    for (int i = NSRC_MAX - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_idx    = 3'(i);
        win_hot    = '0;
        win_hot[i] = 1'b1;
      end
    end
  end

  assign ack_clr  = ack_entry ? win_hot : '0;
  assign pend_clr = (wr_pend ? bus.d_in : '0) | ack_clr;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register here is a plain flop and is
    // cleared explicitly, there is no memory array to leave unreset.
    if (reset) begin
      mask      <= '0;
      vbase_hi  <= '0;
      pending   <= '0;
      ack_idx   <= '0;
      int_n_q   <= 1'b1;
      rd_active <= 1'b0;
    end else begin
      if (wr_mask)  mask     <= bus.d_in & SRC_MASK;
      if (wr_vbase) vbase_hi <= bus.d_in[7:4];
      // A new edge on a bit being cleared in the same clk keeps the bit set.
      pending   <= (pending & ~pend_clr) | rise_v;
      if (ack_entry) ack_idx <= win_idx;
      int_n_q   <= ~any_elig;
      rd_active <= rd_stb | (rd_active & rd_hold);
    end
  end

`ifdef Z80MINI_INTCTL_NESTING_EN
  logic                wr_insrv;
  logic [NSRC_MAX-1:0] eoi_hot;

  assign wr_insrv = wr_stb & (bus.a[1:0] == REG_INSRV);

  // blocked[i] is set when any in-service source has index <= i.
  // eoi_hot selects the highest-priority (lowest index) in-service bit.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    blocked = '0;
    eoi_hot = '0;
    for (int i = 0; i < NSRC_MAX; i++) begin
      if (insrv[i] && !seen) eoi_hot[i] = 1'b1;
      seen       = seen | insrv[i];
      blocked[i] = seen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) insrv <= '0;
    else       insrv <= (insrv & ~(wr_insrv ? eoi_hot : '0)) | ack_clr;
  end
`else
  assign insrv   = '0;
  assign blocked = '0;
`endif

  // ---------------------------------------------------------------------------
  // Acknowledge FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ack_stb)       state_d = ACK;
        else if (any_elig) state_d = REQ;
      end
      REQ: begin
        if (ack_stb)        state_d = ACK;
        else if (!any_elig) state_d = IDLE;
      end
      ACK: begin
        if (ack_exit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [7:0] rd_data;

  always_comb begin
    rd_data = '0;
    unique case (bus.a[1:0])
      REG_MASK:  rd_data = mask;
      REG_VBASE: rd_data = {vbase_hi, 4'b0000};
      REG_PEND:  rd_data = pending;
      REG_INSRV: rd_data = insrv;
      default:   rd_data = '0;
    endcase
  end

  logic [7:0] d_out_c;
  logic       d_oe_c;

  always_comb begin
    d_out_c = '0;
    d_oe_c  = 1'b0;
    if (state_q == ACK) begin
      d_oe_c  = 1'b1;
      d_out_c = {vbase_hi, ack_idx, 1'b0};
    end else if (rd_active) begin
      d_oe_c  = 1'b1;
      d_out_c = rd_data;
    end
  end

  assign bus.d_out = d_out_c;
  assign bus.d_oe  = d_oe_c;
  assign bus.int_n = int_n_q;

endmodule
